row_clear_engine: RTL and testbench

- Downstream consumer of the locked board bitmap (one bit per cell, row-major, row 0 at top, bit index = row*BLOCKS_WIDE + col).
- After each piece locks, the game FSM pulses start. The engine scans the board bottom-up and removes every full row by shifting the rows above it down one row per cycle.
- Returns the compacted board and the count of cleared rows, and maintains the 4-digit BCD score that feeds the 7-segment display.
- Replaces per-row detect/shift sequencing inside the top-level FSM.

---
 rtl/row_clear_engine_pkg.sv | 36 +++
 rtl/row_clear_engine_bcd_score_adder.sv | 34 +++
 rtl/row_clear_engine.sv | 117 +++++++++++
 tb/tb_row_clear_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/row_clear_engine_pkg.sv
// Shared board geometry, FSM encoding and scoring constants for row_clear_engine.
// Combo scoring constants are used only when ROW_CLEAR_COMBO_SCORE_EN is defined.
package row_clear_engine_pkg;

  localparam int BLOCKS_WIDE = 10;
  localparam int BLOCKS_HIGH = 20;
  localparam int ROW_BITS    = 5;
  localparam int BOARD_BITS  = BLOCKS_WIDE * BLOCKS_HIGH;

  localparam logic [2:0]  COUNT_MAX = 3'd7;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  localparam logic [3:0] COMBO_PTS_0 = 4'd0;
  localparam logic [3:0] COMBO_PTS_1 = 4'd1;
  localparam logic [3:0] COMBO_PTS_2 = 4'd3;
  localparam logic [3:0] COMBO_PTS_3 = 4'd5;
  localparam logic [3:0] COMBO_PTS_4 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic logic [3:0] combo_points(input logic [2:0] count);
    case (count)
      3'd0:    combo_points = COMBO_PTS_0;
      3'd1:    combo_points = COMBO_PTS_1;
      3'd2:    combo_points = COMBO_PTS_2;
      3'd3:    combo_points = COMBO_PTS_3;
      default: combo_points = COMBO_PTS_4;
    endcase
  endfunction

endpackage

// File: rtl/row_clear_engine_bcd_score_adder.sv
// Combinational 4-digit BCD adder: score + small binary addend (<= 8),
// saturating at 9999 instead of wrapping.
module row_clear_engine_bcd_score_adder
  import row_clear_engine_pkg::*;
(
  input  logic [15:0] i_score,
  input  logic [3:0]  i_addend,
  output logic [15:0] o_sum
);

  logic [4:0]  w_carry;
  logic [4:0]  w_dsum;
  logic [15:0] w_sum;

  // The addend enters as the carry into the ones digit; each digit sum is <= 17,
  // so one decimal correction and a single-bit carry suffice per digit.
  always_comb begin
    w_carry = {1'b0, i_addend};
    w_dsum  = '0;
    w_sum   = '0;
    for (int i = 0; i < 4; i++) begin
      w_dsum = {1'b0, i_score[4*i +: 4]} + w_carry;
      if (w_dsum > 5'd9) begin
        w_sum[4*i +: 4] = 4'(w_dsum - 5'd10);
        w_carry         = 5'd1;
      end else begin
        w_sum[4*i +: 4] = w_dsum[3:0];
        w_carry         = 5'd0;
      end
    end
    o_sum = (w_carry != 5'd0) ? SCORE_MAX : w_sum;
  end

endmodule

// File: rtl/row_clear_engine.sv
// Scans a locked board bottom-up, collapses full rows and keeps the BCD score.
// Define ROW_CLEAR_COMBO_SCORE_EN for combo points (0,1,3,5,8) instead of points = rows.
module row_clear_engine
  import row_clear_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_score_clr,
  input  logic [BOARD_BITS-1:0] i_board_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BOARD_BITS-1:0] o_board_out,
  output logic [2:0]            o_rows_cleared,
  output logic [15:0]           o_score
);

  state_t                r_state, w_next_state;
  logic [BOARD_BITS-1:0] r_board;
  logic [ROW_BITS-1:0]   r_scan_row;
  logic [ROW_BITS-1:0]   r_shift_row;
  logic [2:0]            r_count;
  logic [2:0]            r_rows_cleared;
  logic [15:0]           r_score;
  logic                  w_row_full;
  logic [3:0]            w_points;
  logic [15:0]           w_score_sum;

  assign w_row_full = &r_board[int'(r_scan_row) * BLOCKS_WIDE +: BLOCKS_WIDE];

`ifdef ROW_CLEAR_COMBO_SCORE_EN
  assign w_points = combo_points(r_count);
`else
  assign w_points = {1'b0, r_count};
`endif

  row_clear_engine_bcd_score_adder u_adder (
    .i_score  (r_score),
    .i_addend (w_points),
    .o_sum    (w_score_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_SCAN;
      ST_SCAN: begin
        if (w_row_full)              w_next_state = ST_SHIFT;
        else if (r_scan_row == '0)   w_next_state = ST_FIN;
      end
      ST_SHIFT: if (r_shift_row == '0) w_next_state = ST_SCAN;
      ST_FIN:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state == ST_SCAN) || (r_state == ST_SHIFT);
    o_done         = (r_state == ST_FIN);
    // During the done cycle the fresh count is shown before it is registered.
    o_rows_cleared = (r_state == ST_FIN) ? r_count : r_rows_cleared;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_board        <= '0;
      r_scan_row     <= '0;
      r_shift_row    <= '0;
      r_count        <= '0;
      r_rows_cleared <= '0;
      r_score        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_board    <= i_board_in;
            r_scan_row <= ROW_BITS'(BLOCKS_HIGH - 1);
            r_count    <= '0;
          end
        end
        ST_SCAN: begin
          if (w_row_full) begin
            r_shift_row <= r_scan_row;
            r_count     <= (r_count == COUNT_MAX) ? r_count : r_count + 3'd1;
          end else if (r_scan_row != '0) begin
            r_scan_row <= r_scan_row - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_shift_row != '0) begin
            r_board[int'(r_shift_row) * BLOCKS_WIDE +: BLOCKS_WIDE] <=
              r_board[(int'(r_shift_row) - 1) * BLOCKS_WIDE +: BLOCKS_WIDE];
            r_shift_row <= r_shift_row - 1'b1;
          end else begin
            r_board[BLOCKS_WIDE-1:0] <= '0;
          end
        end
        ST_FIN:  r_rows_cleared <= r_count;
        default: ;
      endcase

      if (i_score_clr)            r_score <= '0;
      else if (r_state == ST_FIN) r_score <= w_score_sum;
    end
  end

  assign o_board_out = r_board;
  assign o_score     = r_score;

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed self-checking bench for row_clear_engine and its BCD score adder.
module tb_row_clear_engine;
  import row_clear_engine_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_start = 1'b0;
  logic                  i_score_clr = 1'b0;
  logic [BOARD_BITS-1:0] i_board_in = '0;
  logic                  o_busy, o_done;
  logic [BOARD_BITS-1:0] o_board_out;
  logic [2:0]            o_rows_cleared;
  logic [15:0]           o_score;

  logic [15:0] a_score = '0;
  logic [3:0]  a_addend = '0;
  logic [15:0] a_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  row_clear_engine dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_score_clr    (i_score_clr),
    .i_board_in     (i_board_in),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_board_out    (o_board_out),
    .o_rows_cleared (o_rows_cleared),
    .o_score        (o_score)
  );

  row_clear_engine_bcd_score_adder u_adder (
    .i_score  (a_score),
    .i_addend (a_addend),
    .o_sum    (a_sum)
  );

  task automatic check(input string tag, input logic [BOARD_BITS-1:0] obs,
                       input logic [BOARD_BITS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adder_vec(input logic [15:0] s, input logic [3:0] a, input logic [15:0] exp);
    a_score  = s;
    a_addend = a;
    #1;
    check($sformatf("adder_%04h_plus_%0d", s, a), BOARD_BITS'(a_sum), BOARD_BITS'(exp));
  endtask

  // Launches one operation; optionally pulses a second start while busy and
  // optionally asserts score_clr in the done cycle. Returns cycles from start to done.
  task automatic run_op(input logic [BOARD_BITS-1:0] b, input int inj_at,
                        input logic [BOARD_BITS-1:0] inj_b, input bit clr_on_done,
                        output int lat);
    @(negedge clk);
    i_board_in = b;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat     = 1;
    check("busy_cycle1", BOARD_BITS'(o_busy), BOARD_BITS'(1));
    while (lat < 600) begin
      i_start = (lat == inj_at);
      if (lat == inj_at) i_board_in = inj_b;
      if (o_done) begin
        if (clr_on_done) i_score_clr = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    check("busy_low_at_done", BOARD_BITS'(o_busy), BOARD_BITS'(0));
  endtask

  initial begin
    logic [BOARD_BITS-1:0] b_empty, b_one, b_four, b_top7, b_full, exp_one;
    logic [15:0] s3, s4, s5, s6;
    int lat;
    bit saw_done;

    b_empty = '0;
    b_one = '0;  b_one[199:190] = '1;  b_one[180] = 1'b1;
    b_four = '0; b_four[199:160] = '1;
    b_top7 = '0; b_top7[69:0] = '1;
    b_full = '1;
    exp_one = '0; exp_one[190] = 1'b1;
`ifdef ROW_CLEAR_COMBO_SCORE_EN
    s3 = 16'h0009; s4 = 16'h0017; s5 = 16'h0025; s6 = 16'h0026;
`else
    s3 = 16'h0005; s4 = 16'h0012; s5 = 16'h0019; s6 = 16'h0020;
`endif

    // Stand-alone adder vectors, including carry chains and saturation.
    adder_vec(16'h0095, 4'd7, 16'h0102);
    adder_vec(16'h0999, 4'd1, 16'h1000);
    adder_vec(16'h9990, 4'd8, 16'h9998);
    adder_vec(16'h9997, 4'd4, 16'h9999);
    adder_vec(16'h9999, 4'd8, 16'h9999);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  BOARD_BITS'(o_busy), BOARD_BITS'(0));
    check("rst_done",  BOARD_BITS'(o_done), BOARD_BITS'(0));
    check("rst_board", o_board_out, '0);
    check("rst_rows",  BOARD_BITS'(o_rows_cleared), BOARD_BITS'(0));
    check("rst_score", BOARD_BITS'(o_score), BOARD_BITS'(0));

    // Empty board.
    run_op(b_empty, -1, '0, 1'b0, lat);
    check("empty_latency", BOARD_BITS'(lat), BOARD_BITS'(21));
    check("empty_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(0));
    check("empty_board", o_board_out, '0);
    @(negedge clk);
    check("empty_done_pulse", BOARD_BITS'(o_done), BOARD_BITS'(0));
    check("empty_score", BOARD_BITS'(o_score), BOARD_BITS'(0));

    // Bottom row full with one block above it.
    run_op(b_one, -1, '0, 1'b0, lat);
    check("one_latency", BOARD_BITS'(lat), BOARD_BITS'(42));
    check("one_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(1));
    check("one_board", o_board_out, exp_one);
    @(negedge clk);
    check("one_score", BOARD_BITS'(o_score), BOARD_BITS'(16'h0001));
    check("one_rows_hold", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(1));
    check("one_board_hold", o_board_out, exp_one);

    // Four bottom rows full.
    run_op(b_four, -1, '0, 1'b0, lat);
    check("four_latency", BOARD_BITS'(lat), BOARD_BITS'(105));
    check("four_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(4));
    check("four_board", o_board_out, '0);
    @(negedge clk);
    check("four_score", BOARD_BITS'(o_score), BOARD_BITS'(s3));

    // Seven full rows at the top, exactly reaching the count ceiling.
    run_op(b_top7, -1, '0, 1'b0, lat);
    check("top7_latency", BOARD_BITS'(lat), BOARD_BITS'(77));
    check("top7_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(7));
    check("top7_board", o_board_out, '0);
    @(negedge clk);
    check("top7_score", BOARD_BITS'(o_score), BOARD_BITS'(s4));

    // All 20 rows full: count saturates at 7.
    run_op(b_full, -1, '0, 1'b0, lat);
    check("full_latency", BOARD_BITS'(lat), BOARD_BITS'(441));
    check("full_rows_sat", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(7));
    check("full_board", o_board_out, '0);
    @(negedge clk);
    check("full_score", BOARD_BITS'(o_score), BOARD_BITS'(s5));

    // A second start while busy must be ignored.
    run_op(b_one, 5, b_full, 1'b0, lat);
    check("ign_latency", BOARD_BITS'(lat), BOARD_BITS'(42));
    check("ign_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(1));
    check("ign_board", o_board_out, exp_one);
    @(negedge clk);
    check("ign_score", BOARD_BITS'(o_score), BOARD_BITS'(s6));

    // Reset in the middle of SHIFT aborts with no score update and no done.
    @(negedge clk);
    i_board_in = b_one;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", BOARD_BITS'(o_busy), BOARD_BITS'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  BOARD_BITS'(o_busy), BOARD_BITS'(0));
    check("midrst_done",  BOARD_BITS'(o_done), BOARD_BITS'(0));
    check("midrst_board", o_board_out, '0);
    check("midrst_score", BOARD_BITS'(o_score), BOARD_BITS'(0));
    check("midrst_rows",  BOARD_BITS'(o_rows_cleared), BOARD_BITS'(0));
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("midrst_no_done", BOARD_BITS'(saw_done), BOARD_BITS'(0));

    // score_clr coinciding with the done cycle wins over the update.
    run_op(b_one, -1, '0, 1'b1, lat);
    check("clr_latency", BOARD_BITS'(lat), BOARD_BITS'(42));
    check("clr_done", BOARD_BITS'(o_done), BOARD_BITS'(1));
    @(negedge clk);
    i_score_clr = 1'b0;
    check("clr_score", BOARD_BITS'(o_score), BOARD_BITS'(0));
    check("clr_rows", BOARD_BITS'(o_rows_cleared), BOARD_BITS'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
